// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, key codes and key map helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-code output bundle
interface keypad_scanner_if;
    logic [3:0] LINE;
    logic [3:0] COLLUMMN;
    logic [3:0] keyword;
    logic       key_valid;
    logic       key_held;

    modport master (
        output LINE,
        output keyword,
        output key_valid,
        output key_held,
        input  COLLUMMN
    );

    modport slave (
        input  LINE,
        input  keyword,
        input  key_valid,
        input  key_held,
        output COLLUMMN
    );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// rtl/keypad_scanner_sync2.sv - parameterised-width two-flop synchronizer with loadable reset value
module sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_rst_val,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_q    <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with press/release debounce and one-cycle key strobe
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    localparam logic [1:0] S_SCAN     = SCAN;
    localparam logic [1:0] S_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] S_HELD     = HELD;

    logic [1:0]    r_state;
    logic [1:0]    r_row;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_col_oh;
    logic [3:0]    r_keyword;
    logic          r_key_valid;
    logic          r_key_held;

    logic [3:0]    w_col_sync;
    logic [3:0]    w_col_s;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_row_onehot;

    // Idle columns read high through the pull-ups, so the synchronizer resets to all ones.
    sync2 #(.W(4)) u_col_sync (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rst_val (4'hF),
        .i_d       (kp.COLLUMMN),
        .o_q       (w_col_sync)
    );

    assign w_col_s      = ~w_col_sync;
    assign w_cnt_nxt    = r_cnt + CW'(1);
    assign w_row_onehot = 4'b0001 << r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_row       <= 2'd0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_col_oh    <= 4'd0;
            r_keyword   <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (is_onehot4(w_col_s)) begin
                            r_col_oh <= w_col_s;
                            r_cnt    <= '0;
                            r_state  <= S_DEBOUNCE;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (w_col_s == r_col_oh) begin
                        if (w_cnt_nxt == CNT_DONE) begin
                            r_cnt       <= '0;
                            r_state     <= S_HELD;
                            r_keyword   <= key_code(r_row, onehot_idx(r_col_oh));
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_HELD: begin
                    // Any contact on the held row (including a second key) restarts the release count.
                    if (w_col_s == 4'd0) begin
                        if (w_cnt_nxt == CNT_DONE) begin
                            r_cnt      <= '0;
                            r_div      <= '0;
                            r_key_held <= 1'b0;
                            r_row      <= r_row + 2'd1;
                            r_state    <= S_SCAN;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    assign kp.LINE      = ~w_row_onehot;
    assign kp.keyword   = r_keyword;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad scanner bench with switch-matrix keypad model and code reference
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pressed = 16'd0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] last_kw = 4'd0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Switch matrix: a closed switch pulls its column low only while its row is driven low.
    always_comb begin
        kp.COLLUMMN = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.LINE[r] && pressed[r*4+c]) kp.COLLUMMN[c] = 1'b0;
    end

    function automatic logic [3:0] model_code(input int r, input int c);
        if (c == 3) return 4'(10 + r);
        if (r == 3) return (c == 0) ? 4'd14 : ((c == 1) ? 4'd0 : 4'd15);
        return 4'(r * 3 + c + 1);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic release_check(input string tag);
        pressed = 16'd0;
        step(DB + 1);
        check({tag, "_held_before_release_done"}, 32'(kp.key_held), 32'd1);
        step(1);
        check({tag, "_held_cleared"}, 32'(kp.key_held), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(kp.key_valid && prev_valid)) else begin
                errors++;
                $error("FAIL valid_twice: observed 1 expected 0");
            end
            if (kp.key_valid) begin
                checks++;
                assert (kp.key_held === 1'b1) else begin
                    errors++;
                    $error("FAIL held_with_valid: observed %0b expected 1", kp.key_held);
                end
                pulses++;
                last_kw = kp.keyword;
            end
        end
        prev_valid = kp.key_valid;
    end

    initial begin
        int base;
        int n;
        int k;
        int r;
        int c;
        int nb;
        logic [3:0] one;
        logic [3:0] exp_kw;
        logic [3:0] line0;
        logic rotated;

        one = 4'b0001;

        // Reset state and free-running row rotation.
        step(2);
        check("rst_line", 32'(kp.LINE), 32'hE);
        check("rst_keyword", 32'(kp.keyword), 32'h0);
        check("rst_valid", 32'(kp.key_valid), 32'h0);
        check("rst_held", 32'(kp.key_held), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("rotate_line", 32'(kp.LINE), 32'(4'(~(one << ((i / SD) % 4)))));
        end

        // Key 5, clean press.
        base = pulses;
        pressed[1*4+1] = 1'b1;
        step(40);
        check("k5_pulses", 32'(pulses - base), 32'd1);
        check("k5_keyword", 32'(kp.keyword), 32'd5);
        check("k5_held", 32'(kp.key_held), 32'd1);
        release_check("k5");
        step(8);
        exp_kw = 4'd5;

        // Key B with contact bounce.
        base = pulses;
        for (int i = 0; i < 5; i++) begin
            pressed[1*4+3] = 1'b1;
            step(1);
            pressed[1*4+3] = 1'b0;
            step(1);
        end
        check("kb_no_early_pulse", 32'(pulses - base), 32'd0);
        pressed[1*4+3] = 1'b1;
        step(50);
        check("kb_pulses", 32'(pulses - base), 32'd1);
        check("kb_keyword", 32'(kp.keyword), 32'd11);
        release_check("kb");
        step(8);
        exp_kw = 4'd11;

        // Keys 1 and 2 together: never reported, scanning continues.
        base = pulses;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        line0 = kp.LINE;
        rotated = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (kp.LINE !== line0) rotated = 1'b1;
        end
        check("k12_pulses", 32'(pulses - base), 32'd0);
        check("k12_keyword", 32'(kp.keyword), 32'(exp_kw));
        check("k12_scanning", 32'(rotated), 32'd1);
        pressed = 16'd0;
        step(8);

        // Hold D, add 0 while held.
        base = pulses;
        pressed[3*4+3] = 1'b1;
        step(40);
        check("kd_pulses", 32'(pulses - base), 32'd1);
        check("kd_keyword", 32'(kp.keyword), 32'd13);
        pressed[3*4+1] = 1'b1;
        step(40);
        check("kd0_no_pulse", 32'(pulses - base), 32'd1);
        check("kd0_keyword", 32'(kp.keyword), 32'd13);
        check("kd0_held", 32'(kp.key_held), 32'd1);
        release_check("kd0");
        step(8);
        check("kd0_release_no_pulse", 32'(pulses - base), 32'd1);
        pressed[3*4+1] = 1'b1;
        step(50);
        check("k0_pulses", 32'(pulses - base), 32'd2);
        check("k0_keyword", 32'(kp.keyword), 32'd0);
        release_check("k0");
        step(8);

        // Randomized presses with random bounce.
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(0, 15);
            r = k / 4;
            c = k % 4;
            nb = $urandom_range(0, 4);
            base = pulses;
            for (int b = 0; b < nb; b++) begin
                pressed[k] = 1'b1;
                step(1);
                pressed[k] = 1'b0;
                step(1);
            end
            pressed[k] = 1'b1;
            step($urandom_range(50, 70));
            check("rnd_pulses", 32'(pulses - base), 32'd1);
            check("rnd_keyword", 32'(last_kw), 32'(model_code(r, c)));
            check("rnd_held", 32'(kp.key_held), 32'd1);
            release_check("rnd");
            step(8);
        end

        // Reset in the middle of debouncing key 7.
        n = 0;
        while (kp.LINE === 4'b1011 && n < 64) begin
            step(1);
            n++;
        end
        while (kp.LINE !== 4'b1011 && n < 128) begin
            step(1);
            n++;
        end
        check("k7_row_found", 32'(kp.LINE), 32'hB);
        base = pulses;
        pressed[2*4+0] = 1'b1;
        step(6);
        rst = 1'b1;
        step(1);
        check("k7_rst_line", 32'(kp.LINE), 32'hE);
        check("k7_rst_valid", 32'(kp.key_valid), 32'd0);
        check("k7_rst_held", 32'(kp.key_held), 32'd0);
        check("k7_rst_keyword", 32'(kp.keyword), 32'd0);
        rst = 1'b0;
        check("k7_no_pulse", 32'(pulses - base), 32'd0);
        step(50);
        check("k7_pulses", 32'(pulses - base), 32'd1);
        check("k7_keyword", 32'(kp.keyword), 32'd7);
        release_check("k7");
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
